// File: rtl/traffic_scheduler.sv
// Two-street traffic light FSM with optional pedestrian WALK phase (enabled by TRAFFIC_PED_WALK_EN).
// Moore outputs from the state register, so lamps change one cycle after the deciding edge; there is no backpressure.
module traffic_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       SA,
    input  logic       SB,
    input  logic       ped_req,
    output logic [2:0] LA,
    output logic [2:0] LB,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_A_GREEN  = 3'd0,
        S_A_YELLOW = 3'd1,
        S_ALLRED_A = 3'd2,
        S_B_GREEN  = 3'd3,
        S_B_YELLOW = 3'd4,
        S_ALLRED_B = 3'd5,
        S_WALK     = 3'd6
    } state_t;

    localparam logic [4:0] GREEN_LAST  = 5'(GREEN_MIN - 1);
    localparam logic [4:0] YELLOW_LAST = 5'(YELLOW_T - 1);
    localparam logic [4:0] ALLRED_LAST = 5'(ALLRED_T - 1);
    localparam logic [4:0] WALK_LAST   = 5'(WALK_T - 1);

    state_t     state_q, state_d;
    logic [4:0] timer_q, timer_d;
    logic       pend_q, pend_d;
    logic       last_b_q, last_b_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_A_GREEN;
            timer_q  <= 5'd0;
            pend_q   <= 1'b0;
            last_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            last_b_q <= last_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        case (state_q)
            S_A_GREEN:
                if (tick && timer_q >= GREEN_LAST && (SB || pend_q))
                    state_d = S_A_YELLOW;
            S_A_YELLOW:
                if (tick && timer_q == YELLOW_LAST)
                    state_d = S_ALLRED_A;
            S_ALLRED_A:
                if (tick && timer_q == ALLRED_LAST) begin
                    if (pend_q) begin
                        state_d  = S_WALK;
                        last_b_d = 1'b0;
                    end else begin
                        state_d = S_B_GREEN;
                    end
                end
            S_B_GREEN:
                if (tick && timer_q >= GREEN_LAST && (SA || !SB || pend_q))
                    state_d = S_B_YELLOW;
            S_B_YELLOW:
                if (tick && timer_q == YELLOW_LAST)
                    state_d = S_ALLRED_B;
            S_ALLRED_B:
                if (tick && timer_q == ALLRED_LAST) begin
                    if (pend_q) begin
                        state_d  = S_WALK;
                        last_b_d = 1'b1;
                    end else begin
                        state_d = S_A_GREEN;
                    end
                end
            S_WALK:
                if (tick && timer_q == WALK_LAST)
                    state_d = last_b_q ? S_A_GREEN : S_B_GREEN;
            default: state_d = S_A_GREEN;
        endcase

        // Dwell restarts on every transition and parks at 31 rather than wrapping.
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = 5'd0;
        else if (tick && timer_q != 5'd31)
            timer_d = timer_q + 5'd1;

`ifdef TRAFFIC_PED_WALK_EN
        if (state_d == S_WALK && state_q != S_WALK)
            pend_d = 1'b0;
        else
            pend_d = pend_q | ped_req;
`else
        pend_d = 1'b0;
`endif
    end

`ifndef TRAFFIC_PED_WALK_EN
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        LA    = 3'b100;
        LB    = 3'b100;
        phase = state_q;
        case (state_q)
            S_A_GREEN:  LA = 3'b001;
            S_A_YELLOW: LA = 3'b010;
            S_B_GREEN:  LB = 3'b001;
            S_B_YELLOW: LB = 3'b010;
            default: ;
        endcase
`ifdef TRAFFIC_PED_WALK_EN
        walk = (state_q == S_WALK);
`else
        walk = 1'b0;
`endif
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Bench for traffic_scheduler: phase-duration reference model checked every cycle plus directed literal sequences.
module tb_traffic_scheduler;

    localparam int GREEN_MIN = 4;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;
`ifdef TRAFFIC_PED_WALK_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b1;
    logic       SA = 1'b0;
    logic       SB = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] LA, LB, phase;
    logic       walk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Reference state: current phase, ticks already spent in it, pending button, street before WALK.
    int m_ph = 0;
    int m_n = 0;
    int m_nx = 0;
    int m_tk = 0;
    bit m_pend = 1'b0;
    bit m_lastb = 1'b0;

    traffic_scheduler #(
        .GREEN_MIN(GREEN_MIN),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .WALK_T   (WALK_T)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .tick   (tick),
        .SA     (SA),
        .SB     (SB),
        .ped_req(ped_req),
        .LA     (LA),
        .LB     (LB),
        .walk   (walk),
        .phase  (phase)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_la(input int p);
        case (p)
            0: return 1;
            1: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_lb(input int p);
        case (p)
            3: return 1;
            4: return 2;
            default: return 4;
        endcase
    endfunction

    // Each green must show its minimum ticks, yellow/all-red/walk run exactly their dwell in ticks.
    always @(posedge clock) begin
        if (!reset) begin
            m_ph = 0; m_n = 0; m_pend = 1'b0; m_lastb = 1'b0;
        end else begin
            m_nx = m_ph;
            if (tick) begin
                m_tk = m_n + 1;
                case (m_ph)
                    0: if (m_tk >= GREEN_MIN && (SB || m_pend)) m_nx = 1;
                    1: if (m_tk == YELLOW_T) m_nx = 2;
                    2, 5: if (m_tk == ALLRED_T) begin
                        if (m_pend) begin
                            m_nx = 6;
                            m_lastb = (m_ph == 5);
                        end else begin
                            m_nx = (m_ph == 2) ? 3 : 0;
                        end
                    end
                    3: if (m_tk >= GREEN_MIN && (SA || !SB || m_pend)) m_nx = 4;
                    4: if (m_tk == YELLOW_T) m_nx = 5;
                    6: if (m_tk == WALK_T) m_nx = m_lastb ? 0 : 3;
                    default: m_nx = 0;
                endcase
                m_n = (m_nx != m_ph) ? 0 : ((m_tk > 31) ? 31 : m_tk);
            end
            if (m_nx == 6 && m_ph != 6) m_pend = 1'b0;
            else if (PED && ped_req) m_pend = 1'b1;
            m_ph = m_nx;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_phase", int'(phase), m_ph);
            chk("model_LA", int'(LA), exp_la(m_ph));
            chk("model_LB", int'(LB), exp_lb(m_ph));
            chk("model_walk", int'(walk), (m_ph == 6) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int e26[7] = '{0, 0, 0, 1, 1, 2, 3};
        int e27[7] = '{3, 3, 3, 4, 4, 5, 0};
        int e28[8] = '{0, 1, 1, 2, 6, 6, 6, 3};
        int seen_walk;

        // Reset held two cycles, then rest with no demand.
        reset = 1'b0; SA = 1'b0; SB = 1'b0; tick = 1'b1;
        step(); step();
        chk_en = 1'b1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_LA", int'(LA), 1);
        chk("rst_LB", int'(LB), 4);
        chk("rst_walk", int'(walk), 0);
        reset = 1'b1;
        repeat (20) step();
        chk("rest_phase", int'(phase), 0);
        chk("rest_LA", int'(LA), 1);

        // Street B demand from reset: 4 green, 2 yellow, 1 all-red, then B green.
        reset = 1'b0; SB = 1'b1;
        step();
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_b_green", int'(phase), e26[i]);
        end
        chk("b_green_LB", int'(LB), 1);

        // B demand drops: B green minimum, yellow, all-red, back to A.
        SB = 1'b0; SA = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("back_to_a", int'(phase), e27[i]);
        end

        // 33 idle ticks: a wrapping timer would read 1 and delay the exit.
        repeat (33) step();
        chk("idle_a_green", int'(phase), 0);
        SB = 1'b1;
        step();
        chk("sat_exit", int'(phase), 1);

        // Tick stall in B yellow with sensor noise must freeze the sequence.
        step(); chk("ay_hold", int'(phase), 1);
        step(); chk("ay_to_allred", int'(phase), 2);
        step(); chk("allred_to_bg", int'(phase), 3);
        SB = 1'b0;
        repeat (4) step();
        chk("bg_to_by", int'(phase), 4);
        step();
        chk("by_second", int'(phase), 4);
        tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            SA = 1'($urandom_range(0, 1));
            SB = 1'($urandom_range(0, 1));
            step();
            chk("stall_by", int'(phase), 4);
        end
        tick = 1'b1; SA = 1'b0; SB = 1'b0;
        step(); chk("resume_allred_b", int'(phase), 5);
        step(); chk("resume_a_green", int'(phase), 0);

`ifdef TRAFFIC_PED_WALK_EN
        repeat (5) step();
        for (int i = 0; i < 8; i++) begin
            ped_req = (i == 0 || i == 4) ? 1'b1 : 1'b0;
            if (i == 5) SB = 1'b1;
            step();
            chk("ped_seq", int'(phase), e28[i]);
            if (e28[i] == 6) begin
                chk("ped_walk_lamp", int'(walk), 1);
                chk("ped_walk_LA", int'(LA), 4);
            end
        end
        ped_req = 1'b0;
        // The press coinciding with WALK entry was absorbed, so B keeps green under SB.
        repeat (6) step();
        chk("absorbed_press", int'(phase), 3);

        SA = 1'b1;
        repeat (4) step();
        chk("bg_to_a", int'(phase), 0);
        SA = 1'b0; SB = 1'b0; ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        for (int k = 0; k < 20 && phase != 3'd1; k++) step();
        chk("reach_a_yellow", int'(phase), 1);
        reset = 1'b0;
        step();
        chk("midrst_phase", int'(phase), 0);
        chk("midrst_LA", int'(LA), 1);
        reset = 1'b1;
        seen_walk = 0;
        repeat (15) begin
            step();
            if (phase == 3'd6) seen_walk++;
        end
        chk("no_walk_after_rst", seen_walk, 0);
`else
        ped_req = 1'b1;
        seen_walk = 0;
        repeat (10) begin
            step();
            if (phase != 3'd0 || walk) seen_walk++;
        end
        ped_req = 1'b0;
        chk("ped_ignored", seen_walk, 0);
`endif

        // Randomized traffic, ticks, presses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) SA = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) SB = 1'($urandom_range(0, 1));
            ped_req = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
